// File: rtl/nn_result_scanner.sv
// nn_result_scanner
//   Snapshots a vector of class scores on Start and then walks the snapshot one word per
//   cycle. It reports the winning class, its score, the gap to the runner-up, and whether
//   the winner clears a threshold.
//
// Ports
//   Clk          single clock, rising edge
//   Reset        synchronous active-high reset
//   Start        scan request, accepted only while idle
//   Probability  NUM_CLASSES packed unsigned scores; class i at [i*PROB_W +: PROB_W]
//   Threshold    minimum winning score for Valid_Class
//   Sel          snapshot channel routed to Sel_Prob
//   Busy         scan in progress (SCAN or DONE)
//   Done         one-cycle pulse, result outputs have just updated
//   Best_Idx     index of highest score (lowest index on ties)
//   Best_Prob    highest score
//   Margin       highest minus second-highest score
//   Valid_Class  Best_Prob >= Threshold at completion
//   Sel_Prob     registered snapshot word selected by Sel, 0 when Sel is out of range
module nn_result_scanner #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned PROB_W      = 16,
    parameter int unsigned IDX_W       = $clog2(NUM_CLASSES)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          Start,
    input  logic [NUM_CLASSES*PROB_W-1:0] Probability,
    input  logic [PROB_W-1:0]             Threshold,
    input  logic [IDX_W-1:0]              Sel,
    output logic                          Busy,
    output logic                          Done,
    output logic [IDX_W-1:0]              Best_Idx,
    output logic [PROB_W-1:0]             Best_Prob,
    output logic [PROB_W-1:0]             Margin,
    output logic                          Valid_Class,
    output logic [PROB_W-1:0]             Sel_Prob
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_CLASSES - 1);
    // One bit wider than Sel so the range check also works when NUM_CLASSES is 2**IDX_W.
    localparam logic [IDX_W:0]   NumCls  = (IDX_W + 1)'(NUM_CLASSES);

    state_e state_q, state_d;

    logic [PROB_W-1:0] snap_q [NUM_CLASSES];
    logic [IDX_W-1:0]  idx_q;
    logic [PROB_W-1:0] best_q, best_d;
    logic [PROB_W-1:0] second_q, second_d;
    logic [IDX_W-1:0]  bidx_q, bidx_d;

    logic [IDX_W-1:0]  best_idx_q;
    logic [PROB_W-1:0] best_prob_q;
    logic [PROB_W-1:0] margin_q;
    logic              valid_q;
    logic [PROB_W-1:0] sel_prob_q;

    logic              accept;
    logic              scanning;
    logic              last;
    logic [PROB_W-1:0] word;

    // ---------------------------------------------------------------- FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (Start) state_d = StScan;
            StScan:  if (idx_q == LastIdx) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // ---------------------------------------------------------------- FSM outputs
    always_comb begin
        Busy     = (state_q != StIdle);
        Done     = (state_q == StDone);
        accept   = (state_q == StIdle) && Start;
        scanning = (state_q == StScan);
        last     = (idx_q == LastIdx);
    end

    // ---------------------------------------------------------------- running best / second
    always_comb begin
        word     = snap_q[idx_q];
        best_d   = best_q;
        second_d = second_q;
        bidx_d   = bidx_q;
        if (idx_q == '0) begin
            // Index 0 seeds the search rather than being compared against stale state.
            best_d   = word;
            second_d = '0;
            bidx_d   = '0;
        end else if (word > best_q) begin
            // Strictly greater only, so ties keep the lower index.
            best_d   = word;
            second_d = best_q;
            bidx_d   = idx_q;
        end else if (word > second_q) begin
            second_d = word;
        end
    end

    // ---------------------------------------------------------------- datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                snap_q[i] <= '0;
            end
            idx_q       <= '0;
            best_q      <= '0;
            second_q    <= '0;
            bidx_q      <= '0;
            best_idx_q  <= '0;
            best_prob_q <= '0;
            margin_q    <= '0;
            valid_q     <= 1'b0;
            sel_prob_q  <= '0;
        end else begin
            if (accept) begin
                for (int i = 0; i < int'(NUM_CLASSES); i++) begin
                    snap_q[i] <= Probability[i*PROB_W +: PROB_W];
                end
                idx_q <= '0;
            end

            if (scanning) begin
                best_q   <= best_d;
                second_q <= second_d;
                bidx_q   <= bidx_d;
                idx_q    <= last ? '0 : idx_q + IDX_W'(1);
                if (last) begin
                    // Results include the final word, so they load on the DONE-entry edge.
                    best_idx_q  <= bidx_d;
                    best_prob_q <= best_d;
                    margin_q    <= best_d - second_d;
                    valid_q     <= (best_d >= Threshold);
                end
            end

            sel_prob_q <= ({1'b0, Sel} < NumCls) ? snap_q[Sel] : '0;
        end
    end

    assign Best_Idx    = best_idx_q;
    assign Best_Prob   = best_prob_q;
    assign Margin      = margin_q;
    assign Valid_Class = valid_q;
    assign Sel_Prob    = sel_prob_q;

endmodule

// File: tb/tb_nn_result_scanner.sv
// Self-checking bench for nn_result_scanner: directed cases plus randomized scans, all
// compared against a behavioural model that works on a plain array of scores.
module tb_nn_result_scanner;

    localparam int unsigned NC = 10;
    localparam int unsigned PW = 16;
    localparam int unsigned IW = $clog2(NC);

    logic             Clk;
    logic             Reset;
    logic             Start;
    logic [NC*PW-1:0] Probability;
    logic [PW-1:0]    Threshold;
    logic [IW-1:0]    Sel;
    logic             Busy;
    logic             Done;
    logic [IW-1:0]    Best_Idx;
    logic [PW-1:0]    Best_Prob;
    logic [PW-1:0]    Margin;
    logic             Valid_Class;
    logic [PW-1:0]    Sel_Prob;

    nn_result_scanner #(
        .NUM_CLASSES (NC),
        .PROB_W      (PW),
        .IDX_W       (IW)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Probability (Probability),
        .Threshold   (Threshold),
        .Sel         (Sel),
        .Busy        (Busy),
        .Done        (Done),
        .Best_Idx    (Best_Idx),
        .Best_Prob   (Best_Prob),
        .Margin      (Margin),
        .Valid_Class (Valid_Class),
        .Sel_Prob    (Sel_Prob)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned snap_m [NC];   // scores the DUT should have captured

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [NC*PW-1:0] pack_prob();
        logic [NC*PW-1:0] p;
        for (int i = 0; i < int'(NC); i++) p[i*PW +: PW] = snap_m[i][PW-1:0];
        return p;
    endfunction

    // Winner = maximum with lowest index; runner-up = maximum of all other positions.
    task automatic model(output int unsigned bi, output int unsigned b, output int unsigned s);
        b  = snap_m[0];
        bi = 0;
        for (int i = 1; i < int'(NC); i++) begin
            if (snap_m[i] > b) begin
                b  = snap_m[i];
                bi = i;
            end
        end
        s = 0;
        for (int i = 0; i < int'(NC); i++) begin
            if (i != int'(bi) && snap_m[i] > s) s = snap_m[i];
        end
    endtask

    task automatic check_result(input string tag);
        int unsigned bi, b, s;
        model(bi, b, s);
        check_eq({tag, ".idx"},   32'(Best_Idx),    bi);
        check_eq({tag, ".prob"},  32'(Best_Prob),   b);
        check_eq({tag, ".margin"}, 32'(Margin),     b - s);
        check_eq({tag, ".valid"}, 32'(Valid_Class), 32'(b >= 32'(Threshold)));
    endtask

    // Pulse Start with snap_m on Probability, optionally trash Probability afterwards,
    // then check latency and results. The edge that samples Start is edge 0; the DONE
    // cycle is closed by edge NC+1, matching the IDLE+NC*SCAN+DONE = NC+2 cycle period.
    task automatic run_scan(input string tag, input bit trash);
        int k;
        Probability = pack_prob();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        if (trash) Probability = '1;
        check_eq({tag, ".busy"}, 32'(Busy), 1);
        k = 0;
        while (k < 3 * int'(NC)) begin
            tick();
            k++;
            if (Done) break;
        end
        check_eq({tag, ".latency"}, k + 1, NC + 1);
        check_result(tag);
        tick();
        check_eq({tag, ".done_1cyc"}, 32'(Done), 0);
        check_eq({tag, ".idle"}, 32'(Busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, ".busy"},   32'(Busy),        0);
        check_eq({tag, ".done"},   32'(Done),        0);
        check_eq({tag, ".idx"},    32'(Best_Idx),    0);
        check_eq({tag, ".prob"},   32'(Best_Prob),   0);
        check_eq({tag, ".margin"}, 32'(Margin),      0);
        check_eq({tag, ".valid"},  32'(Valid_Class), 0);
        check_eq({tag, ".selp"},   32'(Sel_Prob),    0);
    endtask

    initial begin
        int dones [$];
        int seen;
        int unsigned lim;

        Reset       = 1'b1;
        Start       = 1'b0;
        Probability = '0;
        Threshold   = '0;
        Sel         = '0;
        for (int i = 0; i < int'(NC); i++) snap_m[i] = 0;

        // Reset, with Start asserted simultaneously to show Reset wins.
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        check_all_zero("reset");
        Reset = 1'b0;
        tick();

        // Reference vector.
        snap_m = '{100, 200, 50, 900, 10, 0, 0, 0, 0, 300};
        Threshold = 16'd500;
        run_scan("basic", 1'b0);

        // Tie at indices 2 and 7.
        for (int i = 0; i < int'(NC); i++) snap_m[i] = 0;
        snap_m[2] = 700;
        snap_m[7] = 700;
        run_scan("tie", 1'b0);

        // Probability overwritten right after the snapshot edge.
        for (int i = 0; i < int'(NC); i++) snap_m[i] = $urandom_range(0, 1000);
        Threshold = 16'd400;
        run_scan("snapshot", 1'b1);

        // Sel sweep over the snapshot just taken.
        for (int s = 0; s < 16; s++) begin
            Sel = IW'(s);
            tick();
            check_eq($sformatf("sel%0d", s), 32'(Sel_Prob), (s < int'(NC)) ? snap_m[s] : 0);
        end

        // Start held for 30 edges: a new scan every NC+2 cycles, never back-to-back Done.
        for (int i = 0; i < int'(NC); i++) snap_m[i] = $urandom_range(0, 65535);
        Probability = pack_prob();
        Start = 1'b1;
        seen = 0;
        for (int c = 0; c < 45; c++) begin
            tick();
            if (c == 29) Start = 1'b0;
            if (Done) begin
                if (dones.size() > 0 && dones[dones.size()-1] == c - 1) seen++;
                dones.push_back(c);
            end
        end
        check_eq("held.count", dones.size(), 3);
        check_eq("held.back2back", seen, 0);
        for (int i = 1; i < dones.size(); i++) begin
            check_eq($sformatf("held.gap%0d", i), dones[i] - dones[i-1], NC + 2);
        end
        check_result("held");

        // Reset during scan cycle 5.
        Sel = IW'(3);
        Probability = pack_prob();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_all_zero("abort");
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (Done) seen++;
        end
        check_eq("abort.no_done", seen, 0);
        run_scan("after_abort", 1'b0);

        // Randomized scans; narrow ranges force ties and small margins.
        for (int t = 0; t < 20; t++) begin
            lim = (t % 3 == 0) ? 7 : 65535;
            for (int i = 0; i < int'(NC); i++) snap_m[i] = $urandom_range(0, lim);
            Threshold = PW'($urandom_range(0, lim));
            run_scan($sformatf("rand%0d", t), t[0]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
